// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures each newly retired PC/write-data pair from
// the datapath into a small FIFO and drains it to a debug consumer.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [31:0]   PCResult,
    input  logic [31:0]   WriteData,
    input  logic          Capture_en,
    input  logic          Clear,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [31:0]   Out_pc,
    output logic [31:0]   Out_data,
    output logic [AW:0]   Count,
    output logic          Overflow,
    output logic [7:0]    Drop_cnt
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;
    logic [31:0]   r_last_pc;
    logic          r_seen;

    logic w_valid;
    logic w_retire;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_drop;

    // Handshake: an entry transfers on a rising edge where Out_valid and
    // Out_ready are both 1; Out_valid is driven only by Count, never by Out_ready,
    // and the head entry holds steady while Out_ready stays 0.
    assign w_valid   = (r_count != '0);
    assign w_retire  = Capture_en && (!r_seen || (PCResult != r_last_pc));
    assign w_pop     = w_valid && Out_ready;
    assign w_full    = (r_count == LP_DEPTH);
    assign w_push_ok = w_retire && (!w_full || w_pop);
    assign w_drop    = w_retire && !w_push_ok;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_last_pc  <= '0;
            r_seen     <= 1'b0;
        end else if (Clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
            r_seen     <= 1'b0;
        end else begin
            if (Capture_en) begin
                r_last_pc <= PCResult;
                r_seen    <= 1'b1;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // Storage is not reset; stale contents are masked by Count.
    always_ff @(posedge Clk) begin
        if (w_push_ok && !Clear) begin
            r_mem_pc[r_wr_ptr]   <= PCResult;
            r_mem_data[r_wr_ptr] <= WriteData;
        end
    end

    assign Out_valid = w_valid;
    assign Out_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign Out_data  = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign Count     = r_count;
    assign Overflow  = r_overflow;
    assign Drop_cnt  = r_drop_cnt;

endmodule
